// File: rtl/if_prefetch_queue.sv
// Instruction fetch + DEPTH-entry prefetch queue; a request in cycle N reaches decode in cycle N+2.
// Backpressure: fetch stops issuing when queued + in-flight entries reach DEPTH. Redirect flushes everything.
module if_prefetch_queue #(
    parameter int PC_W     = 8,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [PC_W-1:0]            redirect_pc_i,
    output logic                       imem_req_o,
    output logic [PC_W-1:0]            imem_addr_o,
    input  logic [15:0]                imem_rdata_i,
    output logic [15:0]                instr_o,
    output logic [PC_W-1:0]            instr_pc_o,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [15:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    logic [CW-1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;

    // Credit check counts the outstanding response so it always finds room;
    // a same-cycle pop is deliberately not credited to keep the path short.
    assign occupancy = count + CW'(inflight);
    assign issue     = !rst && !redirect_i && (occupancy < DEPTH_C);
    assign push      = inflight && !redirect_i;
    assign pop       = (count != '0) && instr_ready_i && !redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= PC_W'(RESET_PC);
            resp_pc  <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                resp_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr] <= imem_rdata_i;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (count != DEPTH_C);
        end
    end

    assign imem_req_o    = issue;
    assign imem_addr_o   = fetch_pc;
    assign instr_o       = instr_mem[rd_ptr];
    assign instr_pc_o    = pc_mem[rd_ptr];
    assign instr_valid_o = (count != '0);
    assign count_o       = count;
endmodule
